// File: rtl/regfile_hazard_scheduler_pkg.sv
// Shared CPU8 definitions: opcode encodings, instruction field positions,
// in-flight tracking entry and the register-usage decode.
package cpu8_pkg;

    typedef enum logic [2:0] {
        OP_LW   = 3'b000,
        OP_SW   = 3'b001,
        OP_JUMP = 3'b010,
        OP_ADD  = 3'b011,
        OP_ADDI = 3'b100,
        OP_SUB  = 3'b101,
        OP_NOP6 = 3'b110,
        OP_NOP7 = 3'b111
    } opcode_e;

    localparam int unsigned OP_MSB  = 7;
    localparam int unsigned OP_LSB  = 5;
    localparam int unsigned RT_BIT  = 4;
    localparam int unsigned RS_BIT  = 3;
    localparam int unsigned TGT_MSB = 4;

    typedef struct packed {
        logic reads_rt;
        logic reads_rs;
        logic writes;
    } decode_t;

    typedef struct packed {
        logic vld;
        logic wr;
        logic rd;
    } pipe_entry_t;

    function automatic decode_t decode(input logic [7:0] instr);
        decode_t d;
        d = '0;
        case (opcode_e'(instr[OP_MSB:OP_LSB]))
            OP_ADD, OP_SUB: begin
                d.reads_rt = 1'b1;
                d.reads_rs = 1'b1;
                d.writes   = 1'b1;
            end
            OP_ADDI, OP_LW: begin
                d.reads_rs = 1'b1;
                d.writes   = 1'b1;
            end
            OP_SW: begin
                d.reads_rt = 1'b1;
                d.reads_rs = 1'b1;
            end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/regfile_hazard_scheduler_if.sv
// Issue-side handshake and register-file strobe bundle of the hazard scheduler.
interface regfile_hazard_scheduler_if #(
    parameter int unsigned CNT_W = 8
);
    logic             instr_valid;
    logic [7:0]       instr;
    logic             instr_ready;
    logic             id_strobe;
    logic             id_rt;
    logic             id_rs;
    logic             wb_strobe;
    logic             wb_regwrite;
    logic             wb_rd;
    logic             jump_valid;
    logic [4:0]       jump_target;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output instr_valid, instr,
        input  instr_ready, id_strobe, id_rt, id_rs,
        input  wb_strobe, wb_regwrite, wb_rd,
        input  jump_valid, jump_target, stall_count
    );

    modport slave (
        input  instr_valid, instr,
        output instr_ready, id_strobe, id_rt, id_rs,
        output wb_strobe, wb_regwrite, wb_rd,
        output jump_valid, jump_target, stall_count
    );
endinterface

// File: rtl/regfile_hazard_scheduler_inflight_pipe.sv
// Shift register of in-flight instructions from ID to WB; reports which
// registers still have a pending writer that a new reader must wait for.
module inflight_pipe #(
    parameter int unsigned WB_LAT = 3,
    parameter bit          BYPASS = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_vld,
    input  logic       load_wr,
    input  logic       load_rd,
    output logic [1:0] busy,
    output logic       wb_vld,
    output logic       wb_wr,
    output logic       wb_rd
);
    import cpu8_pkg::*;

    // With bypass the WB-stage writer lands before the read, so it is not checked
    localparam int unsigned CHK_DEPTH = BYPASS ? WB_LAT - 1 : WB_LAT;

    pipe_entry_t pipe [WB_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < WB_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= '{vld: load_vld, wr: load_wr, rd: load_rd};
            for (int unsigned i = 1; i < WB_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int unsigned i = 0; i < CHK_DEPTH; i++) begin
            if (pipe[i].vld && pipe[i].wr) begin
                busy[pipe[i].rd] = 1'b1;
            end
        end
    end

    assign wb_vld = pipe[WB_LAT-1].vld;
    assign wb_wr  = pipe[WB_LAT-1].vld & pipe[WB_LAT-1].wr;
    assign wb_rd  = pipe[WB_LAT-1].rd;

endmodule

// File: rtl/regfile_hazard_scheduler.sv
// In-order issue controller for the t0/t1 register file: decodes register use,
// stalls on RAW hazards against in-flight writers, and drives ID/WB strobes.
module regfile_hazard_scheduler
    import cpu8_pkg::*;
#(
    parameter int unsigned WB_LAT = 3,
    parameter bit          BYPASS = 1'b0,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    regfile_hazard_scheduler_if.slave   bus
);

    decode_t          dec;
    logic [1:0]       busy;
    logic             hazard;
    logic             issue;
    logic             is_jump;
    logic             wb_vld;
    logic             wb_wr;
    logic             wb_rd;

    logic             id_strobe_q;
    logic             id_rt_q;
    logic             id_rs_q;
    logic             jump_valid_q;
    logic [4:0]       jump_target_q;
    logic [CNT_W-1:0] stall_cnt_q;

    always_comb begin
        dec     = decode(bus.instr);
        hazard  = (dec.reads_rt & busy[bus.instr[RT_BIT]])
                | (dec.reads_rs & busy[bus.instr[RS_BIT]]);
        issue   = bus.instr_valid & ~hazard;
        is_jump = (opcode_e'(bus.instr[OP_MSB:OP_LSB]) == OP_JUMP);
    end

    inflight_pipe #(
        .WB_LAT (WB_LAT),
        .BYPASS (BYPASS)
    ) u_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_vld (issue),
        .load_wr  (issue & dec.writes),
        .load_rd  (issue & bus.instr[RT_BIT]),
        .busy     (busy),
        .wb_vld   (wb_vld),
        .wb_wr    (wb_wr),
        .wb_rd    (wb_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_strobe_q   <= 1'b0;
            id_rt_q       <= 1'b0;
            id_rs_q       <= 1'b0;
            jump_valid_q  <= 1'b0;
            jump_target_q <= '0;
        end else begin
            id_strobe_q  <= issue;
            jump_valid_q <= issue & is_jump;
            if (issue) begin
                id_rt_q <= bus.instr[RT_BIT];
                id_rs_q <= bus.instr[RS_BIT];
            end
            if (issue && is_jump) begin
                jump_target_q <= bus.instr[TGT_MSB:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (bus.instr_valid && hazard && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign bus.instr_ready = ~hazard;
    assign bus.id_strobe   = id_strobe_q;
    assign bus.id_rt       = id_rt_q;
    assign bus.id_rs       = id_rs_q;
    assign bus.wb_strobe   = wb_vld;
    assign bus.wb_regwrite = wb_wr;
    assign bus.wb_rd       = wb_rd;
    assign bus.jump_valid  = jump_valid_q;
    assign bus.jump_target = jump_target_q;
    assign bus.stall_count = stall_cnt_q;

endmodule

// File: tb/tb_regfile_hazard_scheduler.sv
// Directed bench: cycle table on a BYPASS=0 instance, hand sequences for
// bypass timing, mid-flight reset and stall counter saturation.
module tb_regfile_hazard_scheduler;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    regfile_hazard_scheduler_if #(.CNT_W(8)) ifa ();
    regfile_hazard_scheduler_if #(.CNT_W(8)) ifb ();

    regfile_hazard_scheduler #(
        .WB_LAT (3),
        .BYPASS (1'b0),
        .CNT_W  (8)
    ) dut_nobyp (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    regfile_hazard_scheduler #(
        .WB_LAT (3),
        .BYPASS (1'b1),
        .CNT_W  (8)
    ) dut_byp (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [7:0] ins;
        logic       rdy;
        logic       ids;
        logic       rt;
        logic       rs;
        logic       wbs;
        logic       wr;
        logic       rd;
        logic       jv;
        logic [4:0] jt;
        logic [7:0] sc;
    } vec_t;

    localparam int unsigned NVEC = 25;
    vec_t vecs [NVEC];

    function automatic vec_t row(input logic v, input logic [7:0] ins, input logic rdy,
                                 input logic ids, input logic rt, input logic rs,
                                 input logic wbs, input logic wr, input logic rd,
                                 input logic jv, input logic [4:0] jt, input logic [7:0] sc);
        vec_t r;
        r = '{v: v, ins: ins, rdy: rdy, ids: ids, rt: rt, rs: rs,
              wbs: wbs, wr: wr, rd: rd, jv: jv, jt: jt, sc: sc};
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_a();
        ifa.instr_valid = 1'b0;
        ifa.instr       = 8'hE0;
    endtask

    task automatic idle_b();
        ifb.instr_valid = 1'b0;
        ifb.instr       = 8'hE0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        idle_a();
        idle_b();
        rst_n = 1'b0;

        //            v  ins    rdy ids rt rs wbs wr rd jv jt  sc
        vecs[0]  = row(1, 8'h68, 1,  0,  0, 0, 0,  0, 0, 0, 0, 0);
        vecs[1]  = row(0, 8'hE0, 1,  1,  0, 1, 0,  0, 0, 0, 0, 0);
        vecs[2]  = row(0, 8'hE0, 1,  0,  0, 0, 0,  0, 0, 0, 0, 0);
        vecs[3]  = row(0, 8'hE0, 1,  0,  0, 0, 1,  1, 0, 0, 0, 0);
        vecs[4]  = row(0, 8'hE0, 1,  0,  0, 0, 0,  0, 0, 0, 0, 0);
        vecs[5]  = row(1, 8'h95, 1,  0,  0, 0, 0,  0, 0, 0, 0, 0);
        vecs[6]  = row(1, 8'h68, 0,  1,  1, 0, 0,  0, 0, 0, 0, 0);
        vecs[7]  = row(1, 8'h68, 0,  0,  0, 0, 0,  0, 0, 0, 0, 1);
        vecs[8]  = row(1, 8'h68, 0,  0,  0, 0, 1,  1, 1, 0, 0, 2);
        vecs[9]  = row(1, 8'h68, 1,  0,  0, 0, 0,  0, 0, 0, 0, 3);
        vecs[10] = row(0, 8'hE0, 1,  1,  0, 1, 0,  0, 0, 0, 0, 3);
        vecs[11] = row(0, 8'hE0, 1,  0,  0, 0, 0,  0, 0, 0, 0, 3);
        vecs[12] = row(0, 8'hE0, 1,  0,  0, 0, 1,  1, 0, 0, 0, 3);
        vecs[13] = row(0, 8'hE0, 1,  0,  0, 0, 0,  0, 0, 0, 0, 3);
        vecs[14] = row(1, 8'h12, 1,  0,  0, 0, 0,  0, 0, 0, 0, 3);
        vecs[15] = row(1, 8'h21, 1,  1,  1, 0, 0,  0, 0, 0, 0, 3);
        vecs[16] = row(0, 8'hE0, 1,  1,  0, 0, 0,  0, 0, 0, 0, 3);
        vecs[17] = row(0, 8'hE0, 1,  0,  0, 0, 1,  1, 1, 0, 0, 3);
        vecs[18] = row(0, 8'hE0, 1,  0,  0, 0, 1,  0, 0, 0, 0, 3);
        vecs[19] = row(0, 8'hE0, 1,  0,  0, 0, 0,  0, 0, 0, 0, 3);
        vecs[20] = row(1, 8'h47, 1,  0,  0, 0, 0,  0, 0, 0, 0, 3);
        vecs[21] = row(0, 8'hE0, 1,  1,  0, 0, 0,  0, 0, 1, 7, 3);
        vecs[22] = row(0, 8'hE0, 1,  0,  0, 0, 0,  0, 0, 0, 0, 3);
        vecs[23] = row(0, 8'hE0, 1,  0,  0, 0, 1,  0, 0, 0, 0, 3);
        vecs[24] = row(0, 8'hE0, 1,  0,  0, 0, 0,  0, 0, 0, 0, 3);

        // Reset state
        @(negedge clk);
        chk("reset instr_ready", 32'(ifa.instr_ready), 32'd1);
        chk("reset id_strobe",   32'(ifa.id_strobe),   32'd0);
        chk("reset wb_strobe",   32'(ifa.wb_strobe),   32'd0);
        chk("reset jump_valid",  32'(ifa.jump_valid),  32'd0);
        chk("reset stall_count", 32'(ifa.stall_count), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            ifa.instr_valid = vecs[i].v;
            ifa.instr       = vecs[i].ins;
            @(negedge clk);
            chk($sformatf("row%0d instr_ready", i), 32'(ifa.instr_ready), 32'(vecs[i].rdy));
            chk($sformatf("row%0d id_strobe", i),   32'(ifa.id_strobe),   32'(vecs[i].ids));
            if (vecs[i].ids) begin
                chk($sformatf("row%0d id_rt", i), 32'(ifa.id_rt), 32'(vecs[i].rt));
                chk($sformatf("row%0d id_rs", i), 32'(ifa.id_rs), 32'(vecs[i].rs));
            end
            chk($sformatf("row%0d wb_strobe", i),   32'(ifa.wb_strobe),   32'(vecs[i].wbs));
            chk($sformatf("row%0d wb_regwrite", i), 32'(ifa.wb_regwrite), 32'(vecs[i].wr));
            if (vecs[i].wbs) begin
                chk($sformatf("row%0d wb_rd", i), 32'(ifa.wb_rd), 32'(vecs[i].rd));
            end
            chk($sformatf("row%0d jump_valid", i), 32'(ifa.jump_valid), 32'(vecs[i].jv));
            if (vecs[i].jv) begin
                chk($sformatf("row%0d jump_target", i), 32'(ifa.jump_target), 32'(vecs[i].jt));
            end
            chk($sformatf("row%0d stall_count", i), 32'(ifa.stall_count), 32'(vecs[i].sc));
            @(posedge clk);
            #1;
        end
        idle_a();

        // Bypass instance: ADDI t1 then ADD t0 t0 t1 stalls only two cycles
        ifb.instr_valid = 1'b1;
        ifb.instr       = 8'h95;
        @(negedge clk);
        chk("byp addi ready", 32'(ifb.instr_ready), 32'd1);
        @(posedge clk);
        #1;
        for (int c = 1; c <= 3; c++) begin
            ifb.instr_valid = 1'b1;
            ifb.instr       = 8'h68;
            @(negedge clk);
            chk($sformatf("byp c%0d ready", c),     32'(ifb.instr_ready), (c == 3) ? 32'd1 : 32'd0);
            chk($sformatf("byp c%0d wb_strobe", c), 32'(ifb.wb_strobe),   (c == 3) ? 32'd1 : 32'd0);
            chk($sformatf("byp c%0d id_strobe", c), 32'(ifb.id_strobe),   (c == 1) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
        end
        idle_b();
        @(negedge clk);
        chk("byp add id_strobe",   32'(ifb.id_strobe),   32'd1);
        chk("byp add id_rs",       32'(ifb.id_rs),       32'd1);
        chk("byp add id_rt",       32'(ifb.id_rt),       32'd0);
        chk("byp stall_count",     32'(ifb.stall_count), 32'd2);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
        end
        #1;

        // Reset while ADD is in flight: its write must be dropped
        ifa.instr_valid = 1'b1;
        ifa.instr       = 8'h68;
        @(negedge clk);
        chk("rst add ready", 32'(ifa.instr_ready), 32'd1);
        @(posedge clk);
        #1;
        idle_a();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst id_strobe",   32'(ifa.id_strobe),   32'd0);
        chk("rst stall_count", 32'(ifb.stall_count), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("post-rst c%0d wb_strobe", c), 32'(ifa.wb_strobe),   32'd0);
            chk($sformatf("post-rst c%0d ready", c),     32'(ifa.instr_ready), 32'd1);
            @(posedge clk);
            #1;
        end
        chk("post-rst stall_count", 32'(ifa.stall_count), 32'd0);

        // Dependent ADDs back to back: 3 stalls per 4 cycles, well past 255
        ifa.instr_valid = 1'b1;
        ifa.instr       = 8'h68;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
        end
        #1;
        idle_a();
        @(negedge clk);
        chk("saturated stall_count", 32'(ifa.stall_count), 32'd255);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
        end
        @(negedge clk);
        chk("drained ready", 32'(ifa.instr_ready), 32'd1);
        chk("held stall_count", 32'(ifa.stall_count), 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
